// File: rtl/pkt_meta_merge_out_pkg.sv
// -----------------------------------------------------------------------------
// pkt_meta_merge_out_pkg
// Shared definitions for the packet/metadata merge output stage.
//   - Beat format (134b): [133:132] tag, [131:128] valid count, [127:0] data
//     with byte0 at [127:120].
//   - Metadata format (128b): [127] drop, [126] rewrite_en,
//     [95:48] new dst MAC, [47:0] new src MAC.
// -----------------------------------------------------------------------------
package pkt_meta_merge_out_pkg;

  localparam int PKT_WIDTH  = 134;
  localparam int META_WIDTH = 128;

  // Beat tag field
  localparam int TAG_HI = 133;
  localparam int TAG_LO = 132;

  // Metadata fields
  localparam int META_DROP_BIT    = 127;
  localparam int META_REWRITE_BIT = 126;
  localparam int META_DST_HI      = 95;
  localparam int META_DST_LO      = 48;
  localparam int META_SRC_HI      = 47;
  localparam int META_SRC_LO      = 0;

  // MAC address locations inside the head beat data
  localparam int DATA_DST_HI = 127;
  localparam int DATA_DST_LO = 80;
  localparam int DATA_SRC_HI = 79;
  localparam int DATA_SRC_LO = 32;

  typedef enum logic [1:0] {
    TAG_BODY   = 2'b00,
    TAG_HEAD   = 2'b01,
    TAG_TAIL   = 2'b10,
    TAG_SINGLE = 2'b11
  } tag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  function automatic tag_e beat_tag(input logic [PKT_WIDTH-1:0] beat);
    return tag_e'(beat[TAG_HI:TAG_LO]);
  endfunction

  // A head or single-beat tag opens a new packet.
  function automatic logic is_pkt_start(input tag_e t);
    return (t == TAG_HEAD) || (t == TAG_SINGLE);
  endfunction

endpackage

// File: rtl/pkt_meta_merge_out_sync_fifo.sv
// -----------------------------------------------------------------------------
// pkt_meta_merge_out_sync_fifo
// Single-clock FIFO with a registered read port (block-RAM style).
// A pop in cycle N presents the popped word on o_rd_data in cycle N+1, and the
// word is held until the next pop. Writes to a full FIFO and reads from an
// empty FIFO are ignored.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wr_en/i_wr_data : push
//   i_rd_en        : pop
//   o_rd_data      : registered read data
//   o_count        : current occupancy (0..2**AW)
//   o_empty/o_full : occupancy flags
// -----------------------------------------------------------------------------
module pkt_meta_merge_out_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [AW:0]      o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_ok, rd_ok;

  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == DEPTH_W);
  assign wr_ok     = i_wr_en && !o_full;
  assign rd_ok     = i_rd_en && !o_empty;
  assign o_count   = count_q;
  assign o_rd_data = rd_data_q;

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr_q] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (rd_ok) rd_data_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pkt_meta_merge_out.sv
// -----------------------------------------------------------------------------
// pkt_meta_merge_out
// Buffers packet beats and per-packet metadata, pairs them in arrival order,
// optionally rewrites the Ethernet MAC addresses in the head beat and emits
// the packet. Packets are dropped at admission when the packet FIFO cannot
// take a worst-case packet, or at output when their metadata has drop set.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_pkt_valid, i_pkt    : 134b input beat stream
//   i_meta_valid, i_meta  : one 128b metadata word per packet, packet order
//   o_data_valid, o_data  : 134b output beat stream (no backpressure)
//   o_pkt_drop_cnt        : saturating count of dropped packets
//   o_meta_ovf            : sticky, metadata lost because its FIFO was full
// The output beat is driven straight from the packet FIFO read register, so a
// popped beat appears on the cycle after its pop and the outputs fall to zero
// as soon as reset is asserted.
// -----------------------------------------------------------------------------
module pkt_meta_merge_out
  import pkt_meta_merge_out_pkg::*;
#(
  parameter int PKT_FIFO_AW   = 9,
  parameter int META_FIFO_AW  = 4,
  parameter int MAX_PKT_BEATS = 96
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pkt_valid,
  input  logic [PKT_WIDTH-1:0]  i_pkt,
  input  logic                  i_meta_valid,
  input  logic [META_WIDTH-1:0] i_meta,
  output logic                  o_data_valid,
  output logic [PKT_WIDTH-1:0]  o_data,
  output logic [15:0]           o_pkt_drop_cnt,
  output logic                  o_meta_ovf
);

  localparam logic [PKT_FIFO_AW:0] PKT_DEPTH_W = (PKT_FIFO_AW + 1)'(1 << PKT_FIFO_AW);
  localparam logic [PKT_FIFO_AW:0] MAX_BEATS_W = (PKT_FIFO_AW + 1)'(MAX_PKT_BEATS);

  // FIFO interface
  logic [PKT_WIDTH-1:0]  pkt_rd;
  logic [META_WIDTH-1:0] meta_rd;
  logic [PKT_FIFO_AW:0]  pkt_count, pkt_free;
  logic [META_FIFO_AW:0] meta_count_unused;
  logic                  pkt_empty, pkt_full_unused;
  logic                  meta_empty, meta_full;
  logic                  pkt_wr, pkt_pop, meta_wr, meta_pop;

  // State
  state_e      state_q, state_d;
  logic        beat_vld_q;             // pkt_rd holds a beat popped last cycle
  logic        accept_q, accept_d;     // inside an admitted multi-beat packet
  logic [7:0]  disc_cnt_q, disc_cnt_d; // metadata words still owed a discard
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        ovf_q, ovf_d;

  // Decode
  tag_e        in_tag, rd_tag;
  logic        in_start, admit_ok, adm_drop;
  logic        meta_dec, meta_drop, meta_rewrite, meta_drop_evt;
  logic [16:0] drop_sum;
  logic        meta_unused;

  pkt_meta_merge_out_sync_fifo #(
    .WIDTH (PKT_WIDTH),
    .AW    (PKT_FIFO_AW)
  ) u_pkt_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (pkt_wr),
    .i_wr_data (i_pkt),
    .i_rd_en   (pkt_pop),
    .o_rd_data (pkt_rd),
    .o_count   (pkt_count),
    .o_empty   (pkt_empty),
    .o_full    (pkt_full_unused)
  );

  pkt_meta_merge_out_sync_fifo #(
    .WIDTH (META_WIDTH),
    .AW    (META_FIFO_AW)
  ) u_meta_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (meta_wr),
    .i_wr_data (i_meta),
    .i_rd_en   (meta_pop),
    .o_rd_data (meta_rd),
    .o_count   (meta_count_unused),
    .o_empty   (meta_empty),
    .o_full    (meta_full)
  );

  assign pkt_free     = PKT_DEPTH_W - pkt_count;
  assign rd_tag       = beat_tag(pkt_rd);
  assign meta_drop    = meta_rd[META_DROP_BIT];
  assign meta_rewrite = meta_rd[META_REWRITE_BIT];
  assign meta_unused  = ^meta_rd[125:96];

  // ---------------------------------------------------------------------------
  // Input admission. A discarded packet needs no state of its own: its body
  // and tail beats are ignored simply because accept_q is clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_tag   = beat_tag(i_pkt);
    in_start = i_pkt_valid && is_pkt_start(in_tag);
    admit_ok = (pkt_free >= MAX_BEATS_W);
    adm_drop = in_start && !admit_ok;
    pkt_wr   = i_pkt_valid && (in_start ? admit_ok : accept_q);
    accept_d = accept_q;
    if (in_start) begin
      accept_d = admit_ok && (in_tag == TAG_HEAD);
    end else if (i_pkt_valid && (in_tag == TAG_TAIL)) begin
      accept_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Metadata intake: owed discards are paid off first, in arrival order.
  // ---------------------------------------------------------------------------
  always_comb begin
    meta_dec = i_meta_valid && (disc_cnt_q != 8'd0);
    meta_wr  = i_meta_valid && (disc_cnt_q == 8'd0);
    ovf_d    = ovf_q | (meta_wr && meta_full);
    unique case ({adm_drop, meta_dec})
      2'b10:   disc_cnt_d = (disc_cnt_q == 8'hFF) ? disc_cnt_q : disc_cnt_q + 8'd1;
      2'b01:   disc_cnt_d = disc_cnt_q - 8'd1;
      default: disc_cnt_d = disc_cnt_q;
    endcase
  end

  // Both drop sources can fire in the same cycle, so sum before saturating.
  always_comb begin
    meta_drop_evt = (state_q == ST_HEAD) && meta_drop;
    drop_sum      = {1'b0, drop_cnt_q} + 17'(adm_drop) + 17'(meta_drop_evt);
    drop_cnt_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // ---------------------------------------------------------------------------
  // Output FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Output FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!pkt_empty && !meta_empty) state_d = ST_HEAD;
      ST_HEAD: state_d = (rd_tag == TAG_SINGLE) ? ST_IDLE : ST_BODY;
      ST_BODY: if (beat_vld_q && (rd_tag == TAG_TAIL)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output FSM: pops and output beat. HEAD already pops the next beat so the
  // body follows the head without a bubble; BODY stops popping once the
  // beat on hand is the tail.
  always_comb begin
    pkt_pop      = 1'b0;
    meta_pop     = 1'b0;
    o_data_valid = 1'b0;
    o_data       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!pkt_empty && !meta_empty) begin
          pkt_pop  = 1'b1;
          meta_pop = 1'b1;
        end
      end
      ST_HEAD: begin
        if (!meta_drop) begin
          o_data_valid = 1'b1;
          o_data       = pkt_rd;
          if (meta_rewrite) begin
            o_data[DATA_DST_HI:DATA_DST_LO] = meta_rd[META_DST_HI:META_DST_LO];
            o_data[DATA_SRC_HI:DATA_SRC_LO] = meta_rd[META_SRC_HI:META_SRC_LO];
          end
        end
        if ((rd_tag != TAG_SINGLE) && !pkt_empty) pkt_pop = 1'b1;
      end
      ST_BODY: begin
        if (beat_vld_q && !meta_drop) begin
          o_data_valid = 1'b1;
          o_data       = pkt_rd;
        end
        if (!pkt_empty && !(beat_vld_q && (rd_tag == TAG_TAIL))) pkt_pop = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Remaining state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_vld_q <= 1'b0;
      accept_q   <= 1'b0;
      disc_cnt_q <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      beat_vld_q <= pkt_pop;
      accept_q   <= accept_d;
      disc_cnt_q <= disc_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_pkt_drop_cnt = drop_cnt_q;
  assign o_meta_ovf     = ovf_q;

endmodule

// File: tb/tb_pkt_meta_merge_out.sv
module tb_pkt_meta_merge_out;

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic         i_pkt_valid;
  logic [133:0] i_pkt;
  logic         i_meta_valid;
  logic [127:0] i_meta;
  logic         o_data_valid;
  logic [133:0] o_data;
  logic [15:0]  o_pkt_drop_cnt;
  logic         o_meta_ovf;

  always #5 clk = ~clk;

  pkt_meta_merge_out dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_pkt_valid    (i_pkt_valid),
    .i_pkt          (i_pkt),
    .i_meta_valid   (i_meta_valid),
    .i_meta         (i_meta),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .o_pkt_drop_cnt (o_pkt_drop_cnt),
    .o_meta_ovf     (o_meta_ovf)
  );

  logic [133:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output beat must match the oldest expected beat.
  task automatic monitor();
    logic [133:0] e;
    if (o_data_valid === 1'b1) begin
      n_out++;
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_beat: observed %0h, expected no output", o_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        assert (o_data === e) else begin
          n_err++;
          $error("FAIL beat: observed %0h, expected %0h", o_data, e);
        end
        $display("beat %0d: %0h", n_out, o_data);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    monitor();
  endtask

  function automatic logic [127:0] mk_meta(input bit drop, input bit rw,
                                           input logic [47:0] dst, input logic [47:0] src);
    logic [127:0] m;
    m          = '0;
    m[125:96]  = 30'($urandom);
    m[127]     = drop;
    m[126]     = rw;
    m[95:48]   = dst;
    m[47:0]    = src;
    return m;
  endfunction

  task automatic send_meta(input logic [127:0] m);
    i_meta_valid = 1'b1;
    i_meta       = m;
    cyc();
    i_meta_valid = 1'b0;
  endtask

  // Sends an n-beat packet; keep=0 means the bench expects admission to drop it.
  task automatic send_pkt(input int n, input logic [127:0] m, input bit keep, input bit meta_last);
    for (int i = 0; i < n; i++) begin
      logic [133:0] b;
      logic [133:0] e;
      logic [1:0]   t;
      t = (n == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b00;
      b[133:132] = t;
      b[131:128] = 4'($urandom);
      b[127:0]   = {$urandom, $urandom, $urandom, $urandom};
      if (keep && !m[127]) begin
        e = b;
        if (i == 0 && m[126]) begin
          e[127:80] = m[95:48];
          e[79:32]  = m[47:0];
        end
        exp_q.push_back(e);
      end
      i_pkt_valid = 1'b1;
      i_pkt       = b;
      if (meta_last && i == n - 1) begin
        i_meta_valid = 1'b1;
        i_meta       = m;
      end
      cyc();
      i_meta_valid = 1'b0;
    end
    i_pkt_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
    check(tag, 134'(exp_q.size()), 134'(0));
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    i_pkt_valid  = 1'b0;
    i_meta_valid = 1'b0;
    i_rst_n      = 1'b0;
    repeat (2) cyc();
    exp_q.delete();
    i_rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    logic [127:0] m, m0, m1, m2, mb;
    int base;

    i_rst_n      = 1'b0;
    i_pkt_valid  = 1'b0;
    i_pkt        = '0;
    i_meta_valid = 1'b0;
    i_meta       = '0;
    repeat (2) cyc();
    check("rst_valid", 134'(o_data_valid), 134'(0));
    check("rst_data", o_data, 134'(0));
    check("rst_drop_cnt", 134'(o_pkt_drop_cnt), 134'(0));
    check("rst_ovf", 134'(o_meta_ovf), 134'(0));
    i_rst_n = 1'b1;
    cyc();

    // 4-beat packet, metadata later, MAC rewrite on the head
    m = mk_meta(1'b0, 1'b1, 48'h112233445566, 48'hAABBCCDDEEFF);
    send_pkt(4, m, 1'b1, 1'b0);
    repeat (4) cyc();
    send_meta(m);
    wait_drain(20, "t1_drain");

    // Single-beat packet, no rewrite; output 2 cycles after metadata
    m = mk_meta(1'b0, 1'b0, 48'h0A0B0C0D0E0F, 48'h010203040506);
    send_pkt(1, m, 1'b1, 1'b0);
    send_meta(m);
    check("t2_lat_c1", 134'(o_data_valid), 134'(0));
    cyc();
    check("t2_lat_c2", 134'(o_data_valid), 134'(1));
    cyc();
    check("t2_back_idle", 134'(o_data_valid), 134'(0));
    wait_drain(5, "t2_drain");

    // Three packets, the middle one dropped by its metadata
    m0 = mk_meta(1'b0, 1'b1, 48'hDEADBEEF0001, 48'hCAFEF00D0001);
    m1 = mk_meta(1'b1, 1'b1, 48'hDEADBEEF0002, 48'hCAFEF00D0002);
    m2 = mk_meta(1'b0, 1'b0, 48'hDEADBEEF0003, 48'hCAFEF00D0003);
    send_pkt(3, m0, 1'b1, 1'b0);
    send_pkt(2, m1, 1'b1, 1'b0);
    send_pkt(3, m2, 1'b1, 1'b0);
    send_meta(m0);
    send_meta(m1);
    send_meta(m2);
    wait_drain(40, "t3_drain");
    check("t3_drop_cnt", 134'(o_pkt_drop_cnt), 134'(1));

    // Admission drop: 417 beats leave 95 free entries, so the next head is refused
    do_reset();
    check("t4_drop_cnt_rst", 134'(o_pkt_drop_cnt), 134'(0));
    m = mk_meta(1'b0, 1'b0, 48'h111111111111, 48'h222222222222);
    send_pkt(417, m, 1'b1, 1'b1);
    mb = mk_meta(1'b0, 1'b1, 48'hBAD0BAD0BAD0, 48'hBAD1BAD1BAD1);
    send_pkt(1, mb, 1'b0, 1'b0);
    check("t4_adm_drop", 134'(o_pkt_drop_cnt), 134'(1));
    send_meta(mb);
    wait_drain(1000, "t4_drain_a");
    m = mk_meta(1'b0, 1'b1, 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D);
    send_pkt(2, m, 1'b1, 1'b0);
    send_meta(m);
    wait_drain(20, "t4_drain_c");
    check("t4_drop_cnt_end", 134'(o_pkt_drop_cnt), 134'(1));

    // Metadata overflow: the 17th word with no packets sets the sticky flag
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_meta(mk_meta(1'b0, 1'b0, 48'(i), 48'(i + 100)));
      if (i == 15) check("t5_ovf_16", 134'(o_meta_ovf), 134'(0));
      if (i == 16) check("t5_ovf_17", 134'(o_meta_ovf), 134'(1));
    end
    repeat (5) cyc();
    check("t5_ovf_sticky", 134'(o_meta_ovf), 134'(1));

    // Reset mid-body, then a stray body beat, then a normal packet
    do_reset();
    check("t6_ovf_cleared", 134'(o_meta_ovf), 134'(0));
    m = mk_meta(1'b0, 1'b0, 48'h313131313131, 48'h323232323232);
    send_pkt(8, m, 1'b1, 1'b1);
    base = n_out;
    for (int i = 0; i < 20 && n_out < base + 2; i++) cyc();
    check("t6_started", 134'(n_out - base), 134'(2));
    check("t6_mid_valid", 134'(o_data_valid), 134'(1));
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 134'(o_data_valid), 134'(0));
    check("t6_rst_data", o_data, 134'(0));
    exp_q.delete();
    repeat (2) cyc();
    i_rst_n = 1'b1;
    cyc();
    i_pkt_valid = 1'b1;
    i_pkt       = {2'b00, 4'hF, $urandom, $urandom, $urandom, $urandom};
    cyc();
    i_pkt_valid = 1'b0;
    m = mk_meta(1'b0, 1'b1, 48'h414141414141, 48'h424242424242);
    send_pkt(3, m, 1'b1, 1'b0);
    send_meta(m);
    wait_drain(20, "t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
